truth_table_lut: RTL and testbench

TRUTH_TABLE_LUT -- requirements
Module: truth_table_lut

---
 rtl/truth_table_pkg.sv | 21 ++
 rtl/tt_row_mem.sv | 38 +++
 rtl/truth_table_lut.sv | 111 +++++++++++
 tb/tb_truth_table_lut.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared constants, FSM state type and table-depth helper for the truth-table LUT.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package truth_table_pkg;

    // Default geometry: three logic inputs, one output function.
    localparam int N_IN_DEF  = 3;
    localparam int N_OUT_DEF = 1;

    // OPEN accepts row writes and clears; LOCKED is read-only until reset.
    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } tt_state_e;

    // Number of table rows for a given input count.
    function automatic int tt_depth(input int n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/tt_row_mem.sv
// DEPTH x N_OUT register array: one write port, a clear-all port, one async read port.
// Latency: writes/clears land at the next edge; read is combinational (read-before-write).
// Backpressure: none; always ready, caller qualifies wr_en and clr.
module tt_row_mem
    import truth_table_pkg::*;
#(
    parameter int               N_IN        = N_IN_DEF,
    parameter int               N_OUT       = N_OUT_DEF,
    parameter int               DEPTH       = tt_depth(N_IN),
    parameter logic [N_OUT-1:0] DEFAULT_ROW = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [N_IN-1:0]  wr_addr,
    input  logic [N_OUT-1:0] wr_data,
    input  logic             clr,
    input  logic [N_IN-1:0]  rd_addr,
    output logic [N_OUT-1:0] rd_data
);

    logic [N_OUT-1:0] rows [DEPTH];

    // Reset and clear reload every row; clear has priority over a row write.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                rows[i] <= DEFAULT_ROW;
            end
        end else if (wr_en) begin
            rows[wr_addr] <= wr_data;
        end
    end

    // Combinational read sees the table as it was before this cycle's write.
    assign rd_data = rows[rd_addr];

endmodule

// File: rtl/truth_table_lut.sv
// Programmable truth table: N_OUT functions of N_IN inputs, lockable configuration.
// Latency: one cycle from accepted in_data to registered out_data.
// Backpressure: in_ready = !out_valid | out_ready; result holds while out_ready is low.
module truth_table_lut
    import truth_table_pkg::*;
#(
    parameter int               N_IN        = N_IN_DEF,
    parameter int               N_OUT       = N_OUT_DEF,
    parameter logic [N_OUT-1:0] DEFAULT_ROW = '0
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic [N_OUT-1:0] cfg_data,
    input  logic             cfg_clear,
    input  logic             cfg_lock,
    output logic             cfg_err,
    output logic             locked,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data
);

    localparam int DEPTH = tt_depth(N_IN);

    tt_state_e        state;
    logic             out_vld_q;
    logic             row_wr_en;
    logic             row_clr;
    logic             in_accept;
    logic [N_OUT-1:0] row_rd_data;

    // Writes and clears only reach the table while open; lock in the same
    // cycle still lets them complete because state changes at the edge.
    assign row_wr_en = cfg_valid & cfg_ready;
    assign row_clr   = cfg_clear & (state == OPEN);

    // Reset discards a pending result immediately so no handshake completes
    // in the reset cycle.
    assign out_valid = out_vld_q & ~rst;
    assign in_ready  = ~rst & (~out_vld_q | out_ready);
    assign in_accept = in_valid & in_ready;

    tt_row_mem #(
        .N_IN        (N_IN),
        .N_OUT       (N_OUT),
        .DEPTH       (DEPTH),
        .DEFAULT_ROW (DEFAULT_ROW)
    ) u_row_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (row_wr_en),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .clr     (row_clr),
        .rd_addr (in_data),
        .rd_data (row_rd_data)
    );

    // Lock FSM with registered cfg_ready, locked and one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= OPEN;
            locked    <= 1'b0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
        end else begin
            case (state)
                OPEN: begin
                    cfg_err <= 1'b0;
                    if (cfg_lock) begin
                        state     <= LOCKED;
                        locked    <= 1'b1;
                        cfg_ready <= 1'b0;
                    end
                end
                LOCKED: begin
                    cfg_err <= cfg_valid | cfg_clear;
                end
                default: begin
                    state     <= OPEN;
                    locked    <= 1'b0;
                    cfg_ready <= 1'b1;
                    cfg_err   <= 1'b0;
                end
            endcase
        end
    end

    // Result register: load on accept, drop valid after the output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            out_data  <= '0;
        end else if (in_accept) begin
            out_vld_q <= 1'b1;
            out_data  <= row_rd_data;
        end else if (out_ready) begin
            out_vld_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_truth_table_lut.sv
module tb_truth_table_lut;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Primary DUT (DEFAULT_ROW = 0)
    logic       rst, cfg_valid, cfg_ready, cfg_clear, cfg_lock, cfg_err, locked;
    logic [2:0] cfg_addr, in_data;
    logic [0:0] cfg_data, out_data;
    logic       in_valid, in_ready, out_valid, out_ready;

    // Second DUT (DEFAULT_ROW = 1)
    logic       b_rst, b_cfg_valid, b_cfg_ready, b_cfg_clear, b_cfg_lock, b_cfg_err, b_locked;
    logic [2:0] b_cfg_addr, b_in_data;
    logic [0:0] b_cfg_data, b_out_data;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;

    truth_table_lut #(.N_IN(3), .N_OUT(1), .DEFAULT_ROW(1'b0)) u_dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_clear(cfg_clear), .cfg_lock(cfg_lock),
        .cfg_err(cfg_err), .locked(locked),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    truth_table_lut #(.N_IN(3), .N_OUT(1), .DEFAULT_ROW(1'b1)) u_dut1 (
        .clk(clk), .rst(b_rst),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_addr(b_cfg_addr),
        .cfg_data(b_cfg_data), .cfg_clear(b_cfg_clear), .cfg_lock(b_cfg_lock),
        .cfg_err(b_cfg_err), .locked(b_locked),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        logic exp;
        int   cyc;
        bit   chk_lat;
    } sb_t;
    sb_t exp_q[$];

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic       dat;
    } vec_t;
    vec_t vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // Output monitor: every completed output handshake pops one expected result.
    sb_t e;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL out_spurious: out_valid with nothing expected, out_data=%0d", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", int'(out_data), int'(e.exp));
                if (e.chk_lat) check("latency_cycles", cyc - e.cyc + 1, 1);
            end
        end
    end

    // Evaluate addr a; push expectation once the input handshake completes.
    task automatic eval(input logic [2:0] a, input logic x, input bit lat);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = a;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                total++;
                $display("FAIL in_accept_timeout: in_ready stuck at 0 for addr %0d", a);
                break;
            end
        end
        @(posedge clk); #1;
        if (n <= 50) exp_q.push_back('{exp: x, cyc: cyc, chk_lat: lat});
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic d, input logic lk);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d; cfg_lock = lk;
        @(negedge clk);
        check("cfg_ready_open", int'(cfg_ready), 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_lock = 1'b0;
    endtask

    task automatic drain();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{wr: 1'b1, addr: 3'd7, dat: 1'b1};
        vecs[1] = '{wr: 1'b0, addr: 3'd7, dat: 1'b1};
        vecs[2] = '{wr: 1'b0, addr: 3'd5, dat: 1'b0};
        vecs[3] = '{wr: 1'b0, addr: 3'd0, dat: 1'b0};
        vecs[4] = '{wr: 1'b1, addr: 3'd2, dat: 1'b1};
        vecs[5] = '{wr: 1'b1, addr: 3'd4, dat: 1'b1};
        vecs[6] = '{wr: 1'b0, addr: 3'd2, dat: 1'b1};
        vecs[7] = '{wr: 1'b0, addr: 3'd4, dat: 1'b1};
        vecs[8] = '{wr: 1'b0, addr: 3'd6, dat: 1'b0};
        vecs[9] = '{wr: 1'b0, addr: 3'd7, dat: 1'b1};

        rst = 1'b1; cfg_valid = 1'b0; cfg_clear = 1'b0; cfg_lock = 1'b0;
        cfg_addr = '0; cfg_data = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        b_rst = 1'b1; b_cfg_valid = 1'b0; b_cfg_clear = 1'b0; b_cfg_lock = 1'b0;
        b_cfg_addr = '0; b_cfg_data = '0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data",  int'(out_data),  0);
        check("rst_cfg_err",   int'(cfg_err),   0);
        check("rst_locked",    int'(locked),    0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        check("rst_in_ready",  int'(in_ready),  1);
        @(posedge clk); #1;

        // Table-driven writes and back-to-back evaluations
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) cfg_write(vecs[i].addr, vecs[i].dat, 1'b0);
            else            eval(vecs[i].addr, vecs[i].dat, 1'b1);
        end
        drain();

        // Backpressure: result for 7 must hold while out_ready is low
        out_ready = 1'b0;
        eval(3'd7, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 3'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data",  int'(out_data),  1);
            check("bp_in_ready",  int'(in_ready),  0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        eval(3'd5, 1'b0, 1'b1);
        drain();

        // Read/write collision on row 3: read returns pre-write value
        cfg_valid = 1'b1; cfg_addr = 3'd3; cfg_data = 1'b1;
        in_valid = 1'b1; in_data = 3'd3;
        @(negedge clk);
        check("coll_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        exp_q.push_back('{exp: 1'b0, cyc: cyc, chk_lat: 1'b1});
        cfg_valid = 1'b0; in_valid = 1'b0;
        eval(3'd3, 1'b1, 1'b1);
        drain();

        // Lock: row 5 = 1, row 6 = 1 written in the same cycle as the lock
        cfg_write(3'd5, 1'b1, 1'b0);
        cfg_write(3'd6, 1'b1, 1'b1);
        @(negedge clk);
        check("lock_locked",    int'(locked),    1);
        check("lock_cfg_ready", int'(cfg_ready), 0);
        check("lock_cfg_err0",  int'(cfg_err),   0);
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_addr = 3'd5; cfg_data = 1'b0;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        check("lock_wr_err_pulse", int'(cfg_err), 1);
        @(negedge clk);
        check("lock_wr_err_clear", int'(cfg_err), 0);
        @(posedge clk); #1;
        cfg_clear = 1'b1;
        @(posedge clk); #1;
        cfg_clear = 1'b0;
        @(negedge clk);
        check("lock_clr_err_pulse", int'(cfg_err), 1);
        @(posedge clk); #1;
        eval(3'd5, 1'b1, 1'b1);
        eval(3'd6, 1'b1, 1'b1);
        eval(3'd7, 1'b1, 1'b1);
        eval(3'd3, 1'b1, 1'b1);
        drain();

        // Reset while locked with a result pending
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 3'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("pend_out_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b1;
        cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = 1'b1;
        @(negedge clk);
        check("rstcyc_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0; cfg_valid = 1'b0;
        @(negedge clk);
        check("rst2_out_valid", int'(out_valid), 0);
        check("rst2_locked",    int'(locked),    0);
        check("rst2_cfg_ready", int'(cfg_ready), 1);
        check("rst2_cfg_err",   int'(cfg_err),   0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) eval(3'(i), 1'b0, 1'b1);
        cfg_write(3'd1, 1'b1, 1'b0);
        eval(3'd1, 1'b1, 1'b1);
        drain();
        check("sb_empty", exp_q.size(), 0);

        // DEFAULT_ROW = 1 instance: clear wins over simultaneous write
        check("b_rst_cfg_ready", int'(b_cfg_ready), 1);
        check("b_rst_locked",    int'(b_locked),    0);
        b_cfg_valid = 1'b1; b_cfg_addr = 3'd5; b_cfg_data = 1'b0;
        @(posedge clk); #1;
        b_cfg_valid = 1'b0;
        b_in_valid = 1'b1; b_in_data = 3'd5;
        @(posedge clk);
        @(negedge clk);
        check("b_row5_written", int'(b_out_data), 0);
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        b_cfg_clear = 1'b1; b_cfg_valid = 1'b1; b_cfg_addr = 3'd2; b_cfg_data = 1'b0;
        @(posedge clk); #1;
        b_cfg_clear = 1'b0; b_cfg_valid = 1'b0;
        @(negedge clk);
        check("b_clr_err", int'(b_cfg_err), 0);
        for (int i = 0; i < 8; i++) begin
            b_in_valid = 1'b1; b_in_data = 3'(i);
            @(posedge clk);
            @(negedge clk);
            check("b_clear_row_valid", int'(b_out_valid), 1);
            check("b_clear_row_data",  int'(b_out_data),  1);
        end
        b_in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
